// File: rtl/mem_line_responder.sv
// ---------------------------------------------------------------------------
// mem_line_responder
//
// Memory-side responder for the cache miss / write-through path. It owns the
// word-addressed main-memory array and serves one request at a time:
//   * line fill   : after LATENCY cycles, streams WORDS_PER_LINE words, one
//                   per cycle, in index order, with rsp_last on the final word
//   * single write: after LATENCY cycles, pulses wr_done for one cycle; the
//                   array word is written at the edge that ends that cycle
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  request present (held stable by the requester until accepted)
//   req_ready  idle, able to accept a request
//   req_write  1 = single-word write, 0 = line fill
//   req_addr   byte address (bit 0 ignored)
//   req_wdata  write data
//   rsp_valid  fill word present on rsp_data
//   rsp_data   fill word (0 when rsp_valid=0)
//   rsp_word   word index within the line (0 when rsp_valid=0)
//   rsp_last   final word of the burst
//   wr_done    one-cycle write-commit pulse
//   busy       request in flight (~req_ready)
// ---------------------------------------------------------------------------
module mem_line_responder #(
    parameter int LATENCY        = 4,   // 1..15
    parameter int WORDS_PER_LINE = 8,   // power of two, >= 2
    parameter int DEPTH_LOG2     = 15   // array holds 2**DEPTH_LOG2 16-bit words
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              req_valid,
    output logic                              req_ready,
    input  logic                              req_write,
    input  logic [15:0]                       req_addr,
    input  logic [15:0]                       req_wdata,
    output logic                              rsp_valid,
    output logic [15:0]                       rsp_data,
    output logic [$clog2(WORDS_PER_LINE)-1:0] rsp_word,
    output logic                              rsp_last,
    output logic                              wr_done,
    output logic                              busy
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam int                WORD_W    = $clog2(WORDS_PER_LINE);
    localparam logic [3:0]        LAT_LOAD  = 4'(LATENCY - 1);
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_LINE - 1);
    // Clears the word-in-line bits of a word address.
    localparam logic [14:0]       LINE_MASK = ~15'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_WDONE
    } state_t;

    // Request captured at accept; addr is a word address (line base for fills).
    typedef struct packed {
        logic        write;
        logic [14:0] addr;
        logic [15:0] wdata;
    } req_t;

    state_t            state_q, state_d;
    logic [3:0]        lat_q, lat_d;
    logic [WORD_W-1:0] word_q, word_d;
    req_t              req_q;
    logic              accept;
    logic [14:0]       rd_addr;
    logic [15:0]       rd_data;

    // Byte-lane bit of the address has no meaning for a 16-bit word array.
    logic              unused_addr_lsb;
    assign unused_addr_lsb = req_addr[0];

    logic [15:0] mem [DEPTH];

    assign accept = req_valid && (state_q == S_IDLE);

    // -----------------------------------------------------------------------
    // State register and counters
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lat_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            word_q  <= word_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    word_d = '0;
                    if (LATENCY == 1) begin
                        // No wait cycles: response starts the cycle after accept.
                        state_d = req_write ? S_WDONE : S_BURST;
                        lat_d   = '0;
                    end else begin
                        state_d = S_WAIT;
                        lat_d   = LAT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                // The step that takes the count to zero is also the exit,
                // so the first response lands exactly LATENCY cycles after accept.
                if (lat_q <= 4'd1) begin
                    lat_d   = '0;
                    state_d = req_q.write ? S_WDONE : S_BURST;
                end else begin
                    lat_d = lat_q - 4'd1;
                end
            end
            S_BURST: begin
                if (word_q == LAST_WORD) begin
                    word_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    word_d = word_q + 1'b1;
                end
            end
            S_WDONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                lat_d   = '0;
                word_d  = '0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request latch
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q <= '0;
        end else if (accept) begin
            req_q.write <= req_write;
            req_q.wdata <= req_wdata;
            req_q.addr  <= req_write ? req_addr[15:1] : (req_addr[15:1] & LINE_MASK);
        end
    end

    // -----------------------------------------------------------------------
    // Memory array (not reset). The write is gated purely by the WDONE state,
    // so a reset before that cycle's edge leaves the array untouched.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state_q == S_WDONE) begin
            mem[req_q.addr[DEPTH_LOG2-1:0]] <= req_q.wdata;
        end
    end

    // Line base is aligned, so the add never carries out of the line.
    assign rd_addr = req_q.addr + 15'(word_q);
    assign rd_data = mem[rd_addr[DEPTH_LOG2-1:0]];

    // -----------------------------------------------------------------------
    // Outputs: all decoded from registered state, nothing from req_*.
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready = (state_q == S_IDLE);
        busy      = (state_q != S_IDLE);
        rsp_valid = (state_q == S_BURST);
        rsp_word  = rsp_valid ? word_q : '0;
        rsp_data  = rsp_valid ? rd_data : '0;
        rsp_last  = rsp_valid && (word_q == LAST_WORD);
        wr_done   = (state_q == S_WDONE);
    end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the cache controller's miss and write-through protocol. It sits between cache_arbitration and the backing store.
- Accepts one request at a time: either a 16-byte line fill or a single-word write.
- Line fills are answered with a fixed-latency burst of 8 words, one word per cycle. Writes are acknowledged with a one-cycle done pulse.
- Holds the word-addressed main-memory array internally and replaces the single-word multicycle memory on the cache miss path.

Parameters:
LATENCY, 4, cycles from the request-accept cycle to the first response (rsp_valid or wr_done); legal range 1..15
WORDS_PER_LINE, 8, words per fill burst; must be a power of two
DEPTH_LOG2, 15, log2 of the number of 16-bit words in the array (addresses req_addr[DEPTH_LOG2:1])

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present; requester holds all req_* stable until accepted
req_ready  out  1  responder idle and able to accept a request
req_write  in  1  1 = single-word write, 0 = line fill
req_addr  in  16  byte address; bit 0 is ignored
req_wdata  in  16  write data, used when req_write=1
rsp_valid  out  1  rsp_data holds a fill word this cycle
rsp_data  out  16  fill word
rsp_word  out  3  word index within the line (log2 WORDS_PER_LINE bits)
rsp_last  out  1  asserted together with rsp_valid on the final word of the burst
wr_done  out  1  one-cycle pulse: the write has been committed to the array
busy  out  1  request in flight (~req_ready)

Behaviour:
- Reset:
  - State goes to IDLE immediately on rst_n low (asynchronous).
  - Output reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_word=0, rsp_last=0, wr_done=0, busy=0.
  - The counter and the latched address are cleared.
  - Array contents are not reset; they are undefined at power-up.
  - Reset mid-burst or mid-write abandons the operation. No further rsp_valid or wr_done pulses are produced for it. A write abandoned before its wr_done cycle does not modify the array.
- Accept:
  - A request is accepted in the cycle where req_valid & req_ready are both 1 (cycle t).
  - At the edge ending cycle t, the responder latches req_write, req_wdata and the line address.
  - For a fill, the line address is req_addr with bits [3:0] cleared. For a write, it is the word address req_addr[15:1].
  - The state advances to WAIT and req_ready drops to 0.
  - req_valid while busy is ignored; there is no queueing.
- State machine (IDLE, WAIT, BURST, WDONE):
  - IDLE: req_ready=1. On accept, go to WAIT and load lat_cnt = LATENCY-1.
  - WAIT: decrement lat_cnt. When lat_cnt reaches 0, go to BURST for a fill or WDONE for a write. With LATENCY=1, WAIT lasts 0 cycles and the next state follows accept directly.
  - BURST: rsp_valid=1 for WORDS_PER_LINE consecutive cycles, words streamed in index order 0..7.
    - rsp_data = array[line_word_base + rsp_word].
    - rsp_last=1 only when rsp_word = WORDS_PER_LINE-1.
    - After the last word, return to IDLE.
  - WDONE: wr_done=1 for exactly one cycle. The array word is written at the edge ending this cycle. Then return to IDLE.
- Timing (LATENCY=4, accept in cycle t):
  - Fill: rsp_valid high in cycles t+4..t+11, rsp_last in t+11, req_ready=1 from t+12. Back-to-back fills are therefore separated by 12 cycles minimum.
  - Write: wr_done in cycle t+4, req_ready=1 from t+5.
- Response flow: there is no backpressure on the response. The consumer must take every rsp_valid word in the cycle it is presented.
- Ordering and read-after-write:
  - A fill accepted at or after the write's req_ready return observes the written data.
  - Fill data is read combinationally from the array in each BURST cycle.
- Output discipline:
  - Outputs are registered or decoded directly from state; there is no combinational path from req_* to rsp_*.
  - rsp_data=0 and rsp_word=0 whenever rsp_valid=0.
- Wrap: addresses use the full 16 bits; there is no aliasing at DEPTH_LOG2=15. For smaller DEPTH_LOG2, the upper address bits are ignored (modulo wrap).

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release → req_ready=1, busy=0, rsp_valid=0, wr_done=0. Assert rst_n low asynchronously between clock edges → outputs return to reset values before the next edge.
- Write then fill: write 0xBEEF to 0x0024 (accept at t) → wr_done only in t+4, req_ready at t+5. Then fill 0x002A (accept at t') → rsp_valid in t'+4..t'+11, rsp_word 0..7, the word at index 2 = 0xBEEF, rsp_last only in t'+11.
- Line alignment: preload words 0x1000+i for byte addresses 0x0100..0x010E, then fill 0x010E → rsp_data sequence 0x1000..0x1007 starting at word 0.
- Busy ignore: hold req_valid=1 with alternating addresses during a fill → exactly one burst, and the second request is accepted only at t+12.
- Reset mid-op: start a write of 0x1234 to 0x0040 and pulse rst_n low at t+2 → wr_done is never asserted and a later fill of 0x0040 returns the old value. Start a fill and reset at word 3 → rsp_valid drops immediately and no rsp_last is seen.
- LATENCY=1 build: fill accepted at t → rsp_valid in t+1..t+8. Write accepted at t → wr_done at t+1, req_ready at t+2.
